// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save frame accumulator with a single final carry-propagate resolve
// Samples are folded in through a 4:2 compressor; only RESOLVE performs a full-width add.
module csa_accumulator #(
  parameter int ACC_W = 16,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       sum_in,
  input  logic [8:0]       cout_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       sample_cnt
);

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] RESOLVE = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] sum_acc;
  logic [ACC_W-1:0] carry_acc;
  logic [ACC_W-1:0] x_sum, x_cout;
  logic [ACC_W-1:0] r1_sum, r1_carry, r2_b;
  logic [ACC_W-1:0] r2_sum, r2_carry;
  logic             accept;
  logic             last_sample;

  assign in_ready    = (state == ACCUM) && !reset;
  assign out_valid   = (state == OUTPUT);
  assign accept      = in_valid && in_ready;
  assign last_sample = (sample_cnt + 8'd1) == 8'(COUNT);

  // cout_in has weight 2, so it enters row 2 pre-shifted; bits above ACC_W fall off.
  assign x_sum  = ACC_W'(sum_in);
  assign x_cout = ACC_W'(cout_in) << 1;

  always_comb begin
    r1_sum   = sum_acc ^ carry_acc ^ x_sum;
    r1_carry = (sum_acc & carry_acc) | (sum_acc & x_sum) | (carry_acc & x_sum);
    r2_b     = r1_carry << 1;
    r2_sum   = r1_sum ^ r2_b ^ x_cout;
    r2_carry = ((r1_sum & r2_b) | (r1_sum & x_cout) | (r2_b & x_cout)) << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACCUM;
      sum_acc    <= '0;
      carry_acc  <= '0;
      sample_cnt <= '0;
      result     <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            sum_acc    <= r2_sum;
            carry_acc  <= r2_carry;
            sample_cnt <= sample_cnt + 8'd1;
            if (last_sample || flush) state <= RESOLVE;
          end else if (flush) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          result     <= sum_acc + carry_acc;
          sum_acc    <= '0;
          carry_acc  <= '0;
          sample_cnt <= '0;
          state      <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator (16-bit and 10-bit instances)
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  sum_in = '0;
  logic [8:0]  cout_in = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [15:0] result;
  logic [7:0]  sample_cnt;
  logic        in_ready10, out_valid10;
  logic [9:0]  result10;
  logic [7:0]  sample_cnt10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.ACC_W(16), .COUNT(4)) dut (
    .clk(clk), .reset(reset), .sum_in(sum_in), .cout_in(cout_in),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .sample_cnt(sample_cnt)
  );

  csa_accumulator #(.ACC_W(10), .COUNT(4)) dut10 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .cout_in(cout_in),
    .in_valid(in_valid), .in_ready(in_ready10), .flush(flush),
    .result(result10), .out_valid(out_valid10), .out_ready(out_ready),
    .sample_cnt(sample_cnt10)
  );

  typedef struct {
    int         n;
    logic [8:0] s;
    logic [8:0] c;
    int         fmode;   // 0: frame fills, 1: flush alone afterwards, 2: flush with last sample
    int         exp16;
    int         exp10;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [8:0] s, input logic [8:0] c, input logic f);
    int guard = 0;
    @(negedge clk);
    sum_in = s; cout_in = c; flush = f; in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic flush_alone();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic get_result(input string name, input int e16, input int e10, input int delay);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_result16"}, 32'(result), 32'(e16 & 16'hFFFF));
    check({name, "_result10"}, 32'(result10), 32'(e10 & 10'h3FF));
    repeat (delay) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs[5];
    logic [15:0] held;
    vecs[0] = '{4, 9'd13,  9'd0,   0, 52,   52};
    vecs[1] = '{4, 9'h0FF, 9'h0FF, 0, 3060, 1012};
    vecs[2] = '{2, 9'd13,  9'd0,   1, 26,   26};
    vecs[3] = '{3, 9'd13,  9'd0,   2, 39,   39};
    vecs[4] = '{0, 9'd0,   9'd0,   1, 0,    0};

    #3;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sample_cnt", 32'(sample_cnt), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        send(vecs[v].s, vecs[v].c, (vecs[v].fmode == 2) && (i == vecs[v].n - 1));
      if (vecs[v].fmode == 1) flush_alone();
      check($sformatf("vec%0d_resolve_cycle", v), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_resolve_in_ready", v), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_latency", v), 32'(out_valid), 32'd1);
      get_result($sformatf("vec%0d", v), vecs[v].exp16, vecs[v].exp10, 0);
    end

    // Backpressure with in_valid held high during OUTPUT
    for (int i = 0; i < 4; i++) send(9'd13, 9'd0, 1'b0);
    @(posedge clk);
    #1;
    held = result;
    check("bp_result", 32'(result), 32'd52);
    in_valid = 1'b1; sum_in = 9'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_stable%0d", i), 32'(result), 32'(held));
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    check("bp_no_accept", 32'(sample_cnt), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_in_ready", 32'(in_ready), 32'd1);
    check("bp_cnt_after", 32'(sample_cnt), 32'd0);
    check("bp_result_kept", 32'(result), 32'd52);

    // Asynchronous reset mid-frame
    send(9'd13, 9'd0, 1'b0);
    send(9'd13, 9'd0, 1'b0);
    check("mid_cnt_before", 32'(sample_cnt), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_cnt_cleared", 32'(sample_cnt), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    check("mid_result_cleared", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send(9'd1, 9'd0, 1'b0);
    get_result("after_reset", 4, 4, 0);

    // Randomised frames against an arithmetic reference
    for (int f = 0; f < 30; f++) begin
      int n, mode;
      longint total;
      logic [8:0] s, c;
      n = $urandom_range(1, 4);
      mode = (n == 4) ? 0 : int'($urandom_range(1, 2));
      total = 0;
      for (int i = 0; i < n; i++) begin
        s = 9'($urandom);
        c = 9'($urandom);
        total += longint'(s) + 2 * longint'(c);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(s, c, (mode == 2) && (i == n - 1));
      end
      if (mode == 1) flush_alone();
      get_result($sformatf("rand%0d", f), int'(total % 65536), int'(total % 1024),
                 int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
